// File: rtl/copy_mem_responder_if.sv
// rtl/copy_mem_responder_if.sv - engine memory port, host port, debug flags/counters bundle
interface copy_mem_responder_if #(
  parameter int CNT_W = 16
);
  // engine read port
  logic [31:0]      mem_read_addr;
  logic             mem_read_en;
  logic [31:0]      mem_read_data;
  // engine write port
  logic [31:0]      mem_write_addr;
  logic [31:0]      mem_write_data;
  logic             mem_write_en;
  // host request/acknowledge port
  logic             host_req;
  logic             host_we;
  logic [31:0]      host_addr;
  logic [31:0]      host_wdata;
  logic [31:0]      host_rdata;
  logic             host_ack;
  logic             host_err;
  // debug status
  logic             err_clr;
  logic             err_rd_oob;
  logic             err_wr_oob;
  logic             err_misalign;
  logic             cnt_clr;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  modport slave (
    input  mem_read_addr, mem_read_en,
    output mem_read_data,
    input  mem_write_addr, mem_write_data, mem_write_en,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack, host_err,
    input  err_clr,
    output err_rd_oob, err_wr_oob, err_misalign,
    input  cnt_clr,
    output rd_count, wr_count
  );

  modport master (
    output mem_read_addr, mem_read_en,
    input  mem_read_data,
    output mem_write_addr, mem_write_data, mem_write_en,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack, host_err,
    output err_clr,
    input  err_rd_oob, err_wr_oob, err_misalign,
    output cnt_clr,
    input  rd_count, wr_count
  );
endinterface

// File: rtl/copy_mem_responder.sv
// rtl/copy_mem_responder.sv - scratchpad serving copy-engine reads/writes plus a handshaked host port
module copy_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  copy_mem_responder_if.slave   bus
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_ACK} hstate_e;

  // Contents are deliberately left unreset.
  logic [31:0] mem [DEPTH_WORDS];

  // 33-bit offsets: an address below BASE_ADDR borrows into bit 32 and so fails the range test.
  logic [32:0]   rd_off, wr_off, h_off;
  logic          rd_in, wr_in, h_in;
  logic          rd_ok, wr_ok, h_ok;
  logic [AW-1:0] rd_idx, wr_idx, h_idx;

  assign rd_off = {1'b0, bus.mem_read_addr}  - {1'b0, BASE_ADDR};
  assign wr_off = {1'b0, bus.mem_write_addr} - {1'b0, BASE_ADDR};
  assign h_off  = {1'b0, bus.host_addr}      - {1'b0, BASE_ADDR};

  assign rd_in = rd_off < SPAN;
  assign wr_in = wr_off < SPAN;
  assign h_in  = h_off  < SPAN;

  assign rd_ok = rd_in && (bus.mem_read_addr[1:0]  == 2'b00);
  assign wr_ok = wr_in && (bus.mem_write_addr[1:0] == 2'b00);
  assign h_ok  = h_in  && (bus.host_addr[1:0]      == 2'b00);

  assign rd_idx = rd_off[AW+1:2];
  assign wr_idx = wr_off[AW+1:2];
  assign h_idx  = h_off[AW+1:2];

  hstate_e     state_q;
  logic        host_ack_q;
  logic        host_err_q;
  logic [31:0] host_rdata_q;

  logic rd_fire, e_wr_fire, h_wr_fire, host_stall;

  assign rd_fire    = bus.mem_read_en && rd_ok;
  assign e_wr_fire  = bus.mem_write_en && wr_ok;
  // Any engine write cycle (even a rejected one) holds off a host write.
  assign host_stall = bus.host_we && bus.mem_write_en;
  assign h_wr_fire  = (state_q == H_ACCESS) && bus.host_we && !bus.mem_write_en && h_ok;

  // Zero-latency engine read; same-cycle writes land at the edge, so old data is seen.
  assign bus.mem_read_data = rd_fire ? mem[rd_idx] : 32'h0;

  // Single write port: engine and host writes are mutually exclusive via host_stall.
  always_ff @(posedge clk) begin
    if (e_wr_fire) begin
      mem[wr_idx] <= bus.mem_write_data;
    end else if (h_wr_fire) begin
      mem[h_idx] <= bus.host_wdata;
    end
  end

  logic             err_rd_oob_q, err_rd_oob_d;
  logic             err_wr_oob_q, err_wr_oob_d;
  logic             err_mis_q, err_mis_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Sticky flags and saturating counters; clears take priority over new events.
  always_comb begin
    err_rd_oob_d = err_rd_oob_q | (bus.mem_read_en && !rd_in);
    err_wr_oob_d = err_wr_oob_q | (bus.mem_write_en && !wr_in);
    err_mis_d    = err_mis_q
                 | (bus.mem_read_en  && (bus.mem_read_addr[1:0]  != 2'b00))
                 | (bus.mem_write_en && (bus.mem_write_addr[1:0] != 2'b00));
    if (bus.err_clr) begin
      err_rd_oob_d = 1'b0;
      err_wr_oob_d = 1'b0;
      err_mis_d    = 1'b0;
    end
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (bus.cnt_clr) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (rd_fire && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
      if (e_wr_fire && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // Debug state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_rd_oob_q <= 1'b0;
      err_wr_oob_q <= 1'b0;
      err_mis_q    <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      err_rd_oob_q <= err_rd_oob_d;
      err_wr_oob_q <= err_wr_oob_d;
      err_mis_q    <= err_mis_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  // Host FSM: request -> access (stalled by engine writes) -> one-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= H_IDLE;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        H_IDLE: begin
          host_ack_q <= 1'b0;
          if (bus.host_req) state_q <= H_ACCESS;
        end
        H_ACCESS: begin
          if (!host_stall) begin
            if (!bus.host_we) host_rdata_q <= h_ok ? mem[h_idx] : 32'h0;
            host_err_q <= !h_ok;
            host_ack_q <= 1'b1;
            state_q    <= H_ACK;
          end
        end
        H_ACK: begin
          host_ack_q <= 1'b0;
          state_q    <= H_IDLE;
        end
        default: begin
          host_ack_q <= 1'b0;
          state_q    <= H_IDLE;
        end
      endcase
    end
  end

  assign bus.host_ack     = host_ack_q;
  assign bus.host_err     = host_err_q;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.err_rd_oob   = err_rd_oob_q;
  assign bus.err_wr_oob   = err_wr_oob_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.rd_count     = rd_cnt_q;
  assign bus.wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_copy_mem_responder.sv
// tb/tb_copy_mem_responder.sv - directed self-checking bench for copy_mem_responder
module tb_copy_mem_responder;

  localparam logic [31:0] B     = 32'h0001_0000;
  localparam int          DEPTH = 1024;
  localparam int          CW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  copy_mem_responder_if #(.CNT_W(CW)) bus();

  copy_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(B), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Full host transaction; lat = edges from request until ack is visible (-1 on timeout).
  task automatic host_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat);
    bit got = 0;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
    lat = 0;
    while (!got && lat < 50) begin
      tick();
      lat++;
      if (bus.host_ack) got = 1;
    end
    rd = bus.host_rdata;
    er = bus.host_err;
    if (!got) lat = -1;
    tick();
    bus.host_req = 1'b0; bus.host_we = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  bit          early_ack;

  initial begin
    rst_n = 1'b0;
    bus.mem_read_addr = '0; bus.mem_read_en = 1'b0;
    bus.mem_write_addr = '0; bus.mem_write_data = '0; bus.mem_write_en = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.err_clr = 1'b0; bus.cnt_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // reset state
    check("rst_ack",   32'(bus.host_ack), 0);
    check("rst_err",   32'(bus.host_err), 0);
    check("rst_rdata", bus.host_rdata, 0);
    check("rst_rdoob", 32'(bus.err_rd_oob), 0);
    check("rst_wroob", 32'(bus.err_wr_oob), 0);
    check("rst_mis",   32'(bus.err_misalign), 0);
    check("rst_rdcnt", 32'(bus.rd_count), 0);
    check("rst_wrcnt", 32'(bus.wr_count), 0);
    check("rst_rdata_idle", bus.mem_read_data, 0);

    // host write then same-cycle engine read
    host_op(1'b1, B, 32'h1234_5678, rd, er, lat);
    host_op(1'b1, B + 32'h10, 32'hA5A5_0001, rd, er, lat);
    check("t1_lat", 32'(lat), 2);
    check("t1_err", 32'(er), 0);
    bus.mem_read_addr = B + 32'h10; bus.mem_read_en = 1'b1;
    #1;
    check("t1_eng_rd", bus.mem_read_data, 32'hA5A5_0001);
    tick();
    bus.mem_read_en = 1'b0;
    #1;
    check("t1_rdcnt", 32'(bus.rd_count), 1);
    check("t1_rd_off", bus.mem_read_data, 0);

    // engine burst of four writes, host reads them back
    for (int i = 0; i < 4; i++) begin
      bus.mem_write_addr = B + 32'h100 + 32'(4 * i);
      bus.mem_write_data = 32'(i + 1);
      bus.mem_write_en = 1'b1;
      tick();
    end
    bus.mem_write_en = 1'b0;
    check("t2_wrcnt", 32'(bus.wr_count), 4);
    for (int i = 0; i < 4; i++) begin
      host_op(1'b0, B + 32'h100 + 32'(4 * i), 32'h0, rd, er, lat);
      check("t2_host_rd", rd, 32'(i + 1));
      check("t2_host_err", 32'(er), 0);
    end

    // read-during-write returns old data
    bus.mem_read_addr = B + 32'h100; bus.mem_read_en = 1'b1;
    bus.mem_write_addr = B + 32'h100; bus.mem_write_data = 32'h55; bus.mem_write_en = 1'b1;
    #1;
    check("rdw_old", bus.mem_read_data, 32'h1);
    tick();
    bus.mem_write_en = 1'b0;
    #1;
    check("rdw_new", bus.mem_read_data, 32'h55);
    bus.mem_read_en = 1'b0;
    check("rdw_wrcnt", 32'(bus.wr_count), 5);
    check("rdw_rdcnt", 32'(bus.rd_count), 2);

    // host read captures old data while engine writes the same word
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = B + 32'h104;
    tick();
    bus.mem_write_addr = B + 32'h104; bus.mem_write_data = 32'h66; bus.mem_write_en = 1'b1;
    tick();
    bus.mem_write_en = 1'b0;
    check("hrw_ack", 32'(bus.host_ack), 1);
    check("hrw_old", bus.host_rdata, 32'h2);
    tick();
    bus.host_req = 1'b0;
    bus.mem_read_addr = B + 32'h104; bus.mem_read_en = 1'b1;
    #1;
    check("hrw_new", bus.mem_read_data, 32'h66);
    bus.mem_read_en = 1'b0;
    check("hrw_wrcnt", 32'(bus.wr_count), 6);

    // out-of-range engine write
    bus.mem_write_addr = B + 32'(4 * DEPTH); bus.mem_write_data = 32'hDEAD; bus.mem_write_en = 1'b1;
    tick();
    bus.mem_write_en = 1'b0;
    check("t3_wroob", 32'(bus.err_wr_oob), 1);
    check("t3_rdoob", 32'(bus.err_rd_oob), 0);
    check("t3_mis", 32'(bus.err_misalign), 0);
    check("t3_wrcnt", 32'(bus.wr_count), 6);
    bus.mem_read_addr = B; bus.mem_read_en = 1'b1;
    #1;
    check("t3_word0", bus.mem_read_data, 32'h1234_5678);
    bus.mem_read_en = 1'b0;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t3_clr", 32'(bus.err_wr_oob), 0);
    // clear beats set; then below-base write sets the flag
    bus.mem_write_addr = B - 32'h4; bus.mem_write_data = 32'hBAD0; bus.mem_write_en = 1'b1;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t3_clr_wins", 32'(bus.err_wr_oob), 0);
    tick();
    bus.mem_write_en = 1'b0;
    check("t3_below", 32'(bus.err_wr_oob), 1);
    check("t3_below_cnt", 32'(bus.wr_count), 6);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    // out-of-range engine read
    bus.mem_read_addr = B + 32'(4 * DEPTH); bus.mem_read_en = 1'b1;
    #1;
    check("t3_rd_oob_data", bus.mem_read_data, 0);
    tick();
    bus.mem_read_en = 1'b0;
    check("t3_rd_oob_flag", 32'(bus.err_rd_oob), 1);
    check("t3_rd_oob_cnt", 32'(bus.rd_count), 2);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;

    // misalignment
    bus.mem_read_addr = B + 32'h2; bus.mem_read_en = 1'b1;
    #1;
    check("t4_rd_data", bus.mem_read_data, 0);
    tick();
    bus.mem_read_en = 1'b0;
    check("t4_mis", 32'(bus.err_misalign), 1);
    check("t4_rdoob", 32'(bus.err_rd_oob), 0);
    check("t4_rdcnt", 32'(bus.rd_count), 2);
    host_op(1'b0, B + 32'h2, 32'h0, rd, er, lat);
    check("t4_host_err", 32'(er), 1);
    check("t4_host_lat", 32'(lat), 2);
    host_op(1'b1, B + 32'(4 * DEPTH), 32'hBEEF, rd, er, lat);
    check("t4_host_oob_err", 32'(er), 1);
    bus.mem_read_addr = B; bus.mem_read_en = 1'b1;
    #1;
    check("t4_word0", bus.mem_read_data, 32'h1234_5678);
    bus.mem_read_en = 1'b0;
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    bus.mem_write_addr = B + 32'h106; bus.mem_write_data = 32'h77; bus.mem_write_en = 1'b1;
    tick();
    bus.mem_write_en = 1'b0;
    check("t4_wr_mis", 32'(bus.err_misalign), 1);
    check("t4_wr_mis_cnt", 32'(bus.wr_count), 6);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;

    // host write stalled by five engine writes; cnt_clr on the last one
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = B + 32'h20; bus.host_wdata = 32'hCAFE;
    lat = 0; early_ack = 0;
    tick(); lat++;
    for (int i = 0; i < 5; i++) begin
      bus.mem_write_addr = B + 32'h200 + 32'(4 * i);
      bus.mem_write_data = 32'h100 + 32'(i);
      bus.mem_write_en = 1'b1;
      bus.cnt_clr = (i == 4);
      tick(); lat++;
      if (bus.host_ack) early_ack = 1;
    end
    bus.mem_write_en = 1'b0; bus.cnt_clr = 1'b0;
    check("t5_no_early_ack", 32'(early_ack), 0);
    tick(); lat++;
    check("t5_ack", 32'(bus.host_ack), 1);
    check("t5_lat", 32'(lat), 7);
    check("t5_err", 32'(bus.host_err), 0);
    tick();
    bus.host_req = 1'b0; bus.host_we = 1'b0;
    check("t5_wrcnt_clr", 32'(bus.wr_count), 0);
    bus.mem_read_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_read_addr = B + 32'h200 + 32'(4 * i);
      #1;
      check("t5_eng_word", bus.mem_read_data, 32'h100 + 32'(i));
    end
    bus.mem_read_addr = B + 32'h20;
    #1;
    check("t5_host_word", bus.mem_read_data, 32'hCAFE);
    bus.mem_read_en = 1'b0;

    // reset during host access
    bus.mem_read_addr = B + 32'h1; bus.mem_read_en = 1'b1;
    tick();
    bus.mem_read_addr = B + 32'h10;
    tick();
    bus.mem_read_en = 1'b0;
    check("t6_pre_mis", 32'(bus.err_misalign), 1);
    check("t6_pre_rdcnt", 32'(bus.rd_count), 1);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = B + 32'h30; bus.host_wdata = 32'hBAD;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_ack", 32'(bus.host_ack), 0);
    check("t6_mis", 32'(bus.err_misalign), 0);
    check("t6_rdcnt", 32'(bus.rd_count), 0);
    tick();
    check("t6_ack_hold", 32'(bus.host_ack), 0);
    rst_n = 1'b1;
    lat = 0;
    while (!bus.host_ack && lat < 50) begin
      tick(); lat++;
    end
    check("t6_rereq_lat", 32'(lat), 2);
    tick();
    bus.host_req = 1'b0; bus.host_we = 1'b0;
    bus.mem_read_addr = B + 32'h30; bus.mem_read_en = 1'b1;
    #1;
    check("t6_word", bus.mem_read_data, 32'hBAD);
    bus.mem_read_en = 1'b0;

    // counter saturation
    for (int i = 0; i < 16; i++) begin
      bus.mem_write_addr = B + 32'h300; bus.mem_write_data = 32'(i); bus.mem_write_en = 1'b1;
      bus.mem_read_addr = B + 32'h10; bus.mem_read_en = 1'b1;
      tick();
      if (i == 14) begin
        check("sat_wr_15", 32'(bus.wr_count), 15);
        check("sat_rd_15", 32'(bus.rd_count), 15);
      end
    end
    bus.mem_write_en = 1'b0;
    check("sat_wr_hold", 32'(bus.wr_count), 15);
    check("sat_rd_hold", 32'(bus.rd_count), 15);
    bus.mem_read_addr = B + 32'h300;
    #1;
    check("sat_word", bus.mem_read_data, 32'hF);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0; bus.mem_read_en = 1'b0;
    check("sat_clr_rd", 32'(bus.rd_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
